// File: rtl/lab1_div.sv
// ============================================================================
// Module   : lab1_div
// Brief    : Unsigned restoring divider, one quotient bit per clock, MSB first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lab1_div #(
    parameter int NW = 16,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [NW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic [NW-1:0] quotient,
    output logic [DW-1:0] remainder,
    output logic          busy,
    output logic          done,
    output logic          div_zero
);

    localparam int CW = $clog2(NW + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW:0]   prem_q,  prem_d;
    logic [NW-1:0] work_q,  work_d;
    logic [DW-1:0] dsr_q,   dsr_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [NW-1:0] quot_q,  quot_d;
    logic [DW-1:0] rem_q,   rem_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;
    logic          dz_q,    dz_d;

    // work_q shifts the dividend out at the top while quotient bits enter at the bottom.
    logic [DW:0]   w_shift;
    logic          w_ge;
    logic [DW:0]   w_prem_nxt;
    logic [NW-1:0] w_work_nxt;
    logic          w_last;

    assign w_shift    = {prem_q[DW-1:0], work_q[NW-1]};
    assign w_ge       = (w_shift >= {1'b0, dsr_q});
    assign w_prem_nxt = w_ge ? (w_shift - {1'b0, dsr_q}) : w_shift;
    assign w_work_nxt = {work_q[NW-2:0], w_ge};
    assign w_last     = (cnt_q == CW'(NW - 1));

    always_comb begin
        state_d = state_q;
        prem_d  = prem_q;
        work_d  = work_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = dz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = dividend[DW-1:0];
                        dz_d    = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        work_d  = dividend;
                        dsr_d   = divisor;
                        prem_d  = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                prem_d = w_prem_nxt;
                work_d = w_work_nxt;
                cnt_d  = cnt_q + CW'(1);
                if (w_last) begin
                    quot_d  = w_work_nxt;
                    rem_d   = w_prem_nxt[DW-1:0];
                    dz_d    = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            prem_q  <= '0;
            work_q  <= '0;
            dsr_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            prem_q  <= prem_d;
            work_q  <= work_d;
            dsr_q   <= dsr_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign div_zero  = dz_q;

endmodule

`default_nettype wire

// File: doc/lab1_div.md
LAB1_DIV -- requirements
Module: lab1_div

Interface
REQ-001 The block SHALL have parameter NW, default 16, giving the dividend and quotient width in bits.
REQ-002 The block SHALL have parameter DW, default 8, giving the divisor and remainder width in bits; the block SHALL support only DW <= NW.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port start, input, 1 bit: request a division, sampled on the rising edge of clk.
REQ-006 The block SHALL have port dividend, input, NW bits: unsigned dividend, sampled with start.
REQ-007 The block SHALL have port divisor, input, DW bits: unsigned divisor, sampled with start.
REQ-008 The block SHALL have port quotient, output, NW bits: result of the last completed division.
REQ-009 The block SHALL have port remainder, output, DW bits: remainder of the last completed division.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse when the results update.
REQ-012 The block SHALL have port div_zero, output, 1 bit: the last completed request had divisor == 0.

Function
REQ-013 The block SHALL be an unsigned restoring divider that resolves one quotient bit per clock, MSB first: the inverse operation of the team's sequential multiplier.
REQ-014 The block SHALL implement a state machine with exactly three states: IDLE, CALC and DONE.
REQ-015 In IDLE with start=1 and divisor != 0 at rising edge T0, the block SHALL latch dividend and divisor, clear the partial remainder (DW+1 bits) and the bit counter, enter CALC and raise busy.
REQ-016 In CALC, each edge SHALL perform one iteration: shift {partial remainder, working dividend} left 1; if partial remainder >= divisor, subtract divisor and set quotient LSB to 1, else set it to 0; then increment the counter.
REQ-017 After NW iterations (edge T0+NW), the block SHALL load quotient and remainder from the internal registers, clear div_zero, enter DONE, assert done and drop busy.
REQ-018 In DONE, done SHALL be high for exactly one cycle; the next edge SHALL return to IDLE unconditionally.
REQ-019 Latency SHALL be NW+1 edges from sampling start to done high (17 cycles at default widths).
REQ-020 The quotient, remainder and div_zero outputs SHALL change only on entry to DONE and SHALL hold their values through CALC and IDLE; the internal working registers SHALL remain separate from the outputs.
REQ-021 In IDLE with start=1 and divisor == 0, the block SHALL go directly to DONE at T0 with quotient all-ones, remainder = dividend[DW-1:0] and div_zero=1, and SHALL NOT assert busy.
REQ-022 The block SHALL ignore start in CALC and DONE; ignored requests SHALL NOT be queued.
REQ-023 A start held high continuously SHALL begin a new division in the IDLE cycle that follows each DONE.
REQ-024 The partial remainder SHALL be DW+1 bits so that the compare does not overflow; the final remainder SHALL always be < divisor and fit in DW bits.
REQ-025 Inputs SHALL need to be stable only at the edge where start is sampled.

Reset
REQ-026 While rst=0, the block SHALL force the state to IDLE and clear quotient, remainder, busy, done, div_zero, the counter and all working registers to 0, immediately and without waiting for clk.
REQ-027 A reset during CALC SHALL abort the division with no done pulse, and the outputs SHALL read 0.
REQ-028 After rst is released, the block SHALL accept start on the first rising edge.

Verification
REQ-029 The bench SHALL cover dividend=0x03E8, divisor=0x07 -> after 17 cycles done=1, quotient=0x008E, remainder=0x06, div_zero=0.
REQ-030 The bench SHALL cover dividend=0xFFFF, divisor=0xFF -> quotient=0x0101, remainder=0x00; busy high for exactly 16 cycles.
REQ-031 The bench SHALL cover dividend=0x0005, divisor=0x0A -> quotient=0x0000, remainder=0x05.
REQ-032 The bench SHALL cover dividend=0x1234, divisor=0x00 -> done on the next cycle, quotient=0xFFFF, remainder=0x34, div_zero=1, busy never high.
REQ-033 The bench SHALL cover start pulsed again at cycle 5 of a running division with new operands -> the pulse is ignored and the first result is unchanged and still delivered at cycle 17.
REQ-034 The bench SHALL cover rst driven low at cycle 8 of a division -> all outputs read 0 immediately and no done pulse appears; a fresh start after release gives a correct result.
